fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-cycle MIPS core. It sits directly upstream of the instruction ROM. It holds the program counter and drives the ROM word address every cycle. It selects the next PC from sequential, branch, jump and jump-register sources, and it sequences boot, run, stall and halt behaviour. Because the ROM read is combinational on its address, the fetched instruction is valid in the same cycle that `inst_addr` changes.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TRAP_PC`, 32'h0000_0080, PC value loaded on a misaligned jump-register target (only used when `FETCH_MISALIGN_TRAP_EN` is defined).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: hold PC this cycle.
- `branch_taken` in 1: conditional branch resolved taken.
- `branch_imm` in 16: raw branch immediate (word offset).
- `jump` in 1: J/JAL.
- `jump_index` in 26: J-type target field.
- `jump_reg` in 1: JR/JALR.
- `jr_target` in 32: register target.
- `halt_req` in 1: enter HALT.
- `inst_addr` out 32: byte address to the ROM (PC register).
- `pc_plus4` out 32: `inst_addr + 4`, for link writes.
- `fetch_valid` out 1: the current ROM output is a real instruction.
- `halted` out 1: FSM is in HALT.
- `fetch_count` out 32: number of instructions consumed.
- `misalign_trap` out 1: one-cycle trap flag.

## Operation
- FSM states and transitions:
  - BOOT is entered on reset and always lasts exactly one cycle, then goes to RUN. It exists because the ROM drives a reset value while `reset` is high.
  - RUN goes to HALT on a `halt_req` edge.
  - HALT is left only by reset.
- `fetch_valid` is 1 only in RUN. `halted` is 1 only in HALT.
- Next-PC priority, evaluated at each edge in RUN:
  1. `halt_req`: PC holds and the FSM goes to HALT.
  2. `stall`: PC holds.
  3. `jump_reg`: PC ← `jr_target`.
  4. `jump`: PC ← {`pc_plus4[31:28]`, `jump_index`, 2'b00}.
  5. `branch_taken`: PC ← `pc_plus4` + {{14{`branch_imm[15]`}}, `branch_imm`, 2'b00}.
  6. Otherwise: PC ← `pc_plus4`.
- In BOOT and HALT, PC holds and all redirect inputs are ignored.
- `stall` together with any redirect: the stall wins and the redirect is dropped. Upstream must hold the redirect inputs until the stall clears.
- `fetch_count` increments at every RUN edge with `stall`=0, including the edge on which `halt_req` is accepted.
- Arithmetic:
  - All PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
  - A negative branch offset below 0 wraps in the same way.
  - `fetch_count` wraps from 32'hFFFF_FFFF to 0.
- `pc_plus4` is combinational from the PC register.

## Timing
- Reset values: `inst_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4, `fetch_valid`=0, `halted`=0, `fetch_count`=0, `misalign_trap`=0, state=BOOT.
- Redirect latency: inputs sampled at edge N appear on `inst_addr` after edge N. The new instruction is available from the ROM in that same cycle, so there is one cycle of redirect latency and no bubble.
- The first valid fetch is in the cycle after the first edge with `reset` low.
- `reset` asserted mid-operation takes effect immediately, without waiting for a clock edge, including from HALT or during a stall.
- `misalign_trap` is registered and is high for exactly the one cycle following the trapping edge.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- **Defined:** an accepted `jump_reg` with `jr_target[1:0]` ≠ 0 loads `TRAP_PC` instead of `jr_target`, pulses `misalign_trap`, and still increments `fetch_count`.
- **Undefined:** `jr_target[1:0]` is forced to 2'b00 and `misalign_trap` is tied to 0.
- Branch and jump targets are always word-aligned, so they never trap.

## Test plan
- **Reset and boot:** release reset with `RESET_PC`=0.
  - Cycle 0 after release: `fetch_valid`=0 and `inst_addr`=0.
  - Cycle 1: `fetch_valid`=1 and `inst_addr`=0.
  - Cycle 2: `inst_addr`=4 and `fetch_count`=1.
- **Branch:** at PC 32'h10, `branch_taken` with `branch_imm`=16'hFFFE. Next `inst_addr`=32'h0C.
  - Wrap: at PC 32'hFFFF_FFFC with no redirect, next PC=0.
- **Priority:** at PC 32'h20, assert `jump_reg` (`jr_target`=32'h400), `jump` (`jump_index`=26'h10) and `branch_taken` together. Next PC=32'h400.
  - Repeat with `stall`=1 as well: PC stays 32'h20 and `fetch_count` is unchanged.
- **Halt:** `halt_req` at PC 32'h8 with count 2. Then `halted`=1, `fetch_valid`=0, PC stays 32'h8 and count=3. Later redirects are ignored.
  - Async reset while halted: immediately PC=0, `halted`=0, count=0.
- **Misaligned JR:** `jr_target`=32'h102.
  - With `FETCH_MISALIGN_TRAP_EN`: PC=`TRAP_PC` and `misalign_trap` is high for exactly 1 cycle.
  - Without it: PC=32'h100 and `misalign_trap`=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch stage for the single-cycle MIPS core. It holds the
// program counter, drives the combinational instruction ROM address every
// cycle, and selects the next PC from sequential, branch, jump and
// jump-register sources. A small FSM sequences BOOT -> RUN -> HALT.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : an accepted JR/JALR whose target has nonzero low bits loads
//               TRAP_PC and pulses misalign_trap for one cycle.
//   undefined : jr_target[1:0] is forced to 2'b00, misalign_trap is tied 0.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   stall         in   hold PC this cycle (drops any redirect)
//   branch_taken  in   conditional branch resolved taken
//   branch_imm    in   16-bit word offset for branches
//   jump          in   J/JAL
//   jump_index    in   26-bit J-type target field
//   jump_reg      in   JR/JALR
//   jr_target     in   32-bit register target
//   halt_req      in   request entry into HALT
//   inst_addr     out  PC register, byte address to the ROM
//   pc_plus4      out  inst_addr + 4 (link value)
//   fetch_valid   out  ROM output is a real instruction (RUN only)
//   halted        out  FSM is in HALT
//   fetch_count   out  number of instructions consumed
//   misalign_trap out  one-cycle misaligned JR trap flag
//   fsm_state     out  debug view of the FSM state (BOOT=0, RUN=1, HALT=2)
//
// Handshake note: there is no valid/ready pair on this block. Redirect
// inputs are sampled at the rising edge in RUN only; when stall is high the
// redirect is dropped, so upstream must hold it until stall clears.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jr_target,
  input  logic        halt_req,
  output logic [31:0] inst_addr,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic        misalign_trap,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] branch_off;
  logic [31:0] jump_tgt;

  assign pc_plus4   = pc_q + 32'd4;
  // Word offset, sign-extended and scaled to bytes.
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], jump_index, 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
`else
  // TRAP_PC and the low target bits have no use in this build.
  logic unused_trap_inputs;
  assign unused_trap_inputs = (^TRAP_PC) ^ (^jr_target[1:0]);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d  = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        // One cycle to let the ROM leave its reset output behind.
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // The halt edge still consumes the instruction in flight.
        if (!stall) begin
          count_d = count_q + 32'd1;
        end
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          if (jump_reg) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (jr_target[1:0] != 2'b00) begin
              pc_d   = TRAP_PC;
              trap_d = 1'b1;
            end else begin
              pc_d = jr_target;
            end
`else
            pc_d = {jr_target[31:2], 2'b00};
`endif
          end else if (jump) begin
            pc_d = jump_tgt;
          end else if (branch_taken) begin
            pc_d = pc_plus4 + branch_off;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
  assign misalign_trap = trap_q;
`else
  assign misalign_trap = 1'b0;
`endif

  assign inst_addr   = pc_q;
  assign fetch_count = count_q;
  assign fetch_valid = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with hand-computed expected values.
module tb_fetch_unit;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic        halt_req;
  logic [31:0] inst_addr;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic        misalign_trap;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg),
    .jr_target    (jr_target),
    .halt_req     (halt_req),
    .inst_addr    (inst_addr),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .halted       (halted),
    .fetch_count  (fetch_count),
    .misalign_trap(misalign_trap),
    .fsm_state    (fsm_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking task
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = 16'h0;
    jump         = 1'b0;
    jump_index   = 26'h0;
    jump_reg     = 1'b0;
    jr_target    = 32'h0;
    halt_req     = 1'b0;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_pc_cnt(input string tag, input logic [31:0] pc,
                              input logic [31:0] cnt);
    check_eq({tag, "_pc"}, inst_addr, pc);
    check_eq({tag, "_cnt"}, fetch_count, cnt);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    // Reset state
    check_eq("rst_pc", inst_addr, 32'h0);
    check_eq("rst_pc4", pc_plus4, 32'h4);
    check_eq("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check_eq("rst_halted", {31'b0, halted}, 32'd0);
    check_eq("rst_cnt", fetch_count, 32'd0);
    check_eq("rst_trap", {31'b0, misalign_trap}, 32'd0);
    check_eq("rst_state", {30'b0, fsm_state}, {30'b0, ST_BOOT});

    // Boot: cycle 0 after release, with a redirect that must be ignored
    reset     = 1'b0;
    jump_reg  = 1'b1;
    jr_target = 32'h400;
    #1;
    check_eq("boot0_valid", {31'b0, fetch_valid}, 32'd0);
    check_eq("boot0_pc", inst_addr, 32'h0);
    tick();
    clear_inputs();
    check_eq("boot1_valid", {31'b0, fetch_valid}, 32'd1);
    check_pc_cnt("boot1", 32'h0, 32'd0);
    tick();
    check_pc_cnt("boot2", 32'h4, 32'd1);

    // Jump from 0x4 to 0x10
    jump = 1'b1; jump_index = 26'h4;
    tick();
    clear_inputs();
    check_pc_cnt("jump10", 32'h10, 32'd2);

    // Backward branch: 0x14 - 8 = 0x0C
    branch_taken = 1'b1; branch_imm = 16'hFFFE;
    tick();
    clear_inputs();
    check_pc_cnt("br_back", 32'h0C, 32'd3);

    // JR to the top word, then sequential wrap to 0
    jump_reg = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    check_pc_cnt("jr_top", 32'hFFFF_FFFC, 32'd4);
    check_eq("top_pc4", pc_plus4, 32'h0);
    tick();
    check_pc_cnt("seq_wrap", 32'h0, 32'd5);

    // Negative branch below 0: 4 - 8 wraps to 0xFFFFFFFC
    branch_taken = 1'b1; branch_imm = 16'hFFFE;
    tick();
    clear_inputs();
    check_pc_cnt("br_wrap", 32'hFFFF_FFFC, 32'd6);

    // Jump from the top word: pc_plus4 upper nibble is 0 -> 0x20
    jump = 1'b1; jump_index = 26'h8;
    tick();
    clear_inputs();
    check_pc_cnt("jump20", 32'h20, 32'd7);

    // Priority with stall: everything dropped
    stall = 1'b1;
    jump_reg = 1'b1; jr_target = 32'h400;
    jump = 1'b1; jump_index = 26'h10;
    branch_taken = 1'b1; branch_imm = 16'h0005;
    tick();
    check_pc_cnt("prio_stall", 32'h20, 32'd7);
    // Stall released: jump_reg wins
    stall = 1'b0;
    tick();
    clear_inputs();
    check_pc_cnt("prio_jr", 32'h400, 32'd8);

    // Jump over branch priority, and upper PC bits kept from pc_plus4
    jump_reg = 1'b1; jr_target = 32'h1FFF_FFF0;
    tick();
    clear_inputs();
    check_pc_cnt("jr_hi", 32'h1FFF_FFF0, 32'd9);
    jump = 1'b1; jump_index = 26'h10;
    branch_taken = 1'b1; branch_imm = 16'h0100;
    tick();
    clear_inputs();
    check_pc_cnt("jump_hi", 32'h1000_0040, 32'd10);

    // Forward branch: 0x10000044 + 0x40 = 0x10000084
    branch_taken = 1'b1; branch_imm = 16'h0010;
    tick();
    clear_inputs();
    check_pc_cnt("br_fwd", 32'h1000_0084, 32'd11);

    // Misaligned JR
    jump_reg = 1'b1; jr_target = 32'h102;
    tick();
    clear_inputs();
`ifdef FETCH_MISALIGN_TRAP_EN
    check_pc_cnt("mis_jr", 32'h80, 32'd12);
    check_eq("mis_trap1", {31'b0, misalign_trap}, 32'd1);
    tick();
    check_pc_cnt("mis_next", 32'h84, 32'd13);
    check_eq("mis_trap2", {31'b0, misalign_trap}, 32'd0);
`else
    check_pc_cnt("mis_jr", 32'h100, 32'd12);
    check_eq("mis_trap1", {31'b0, misalign_trap}, 32'd0);
    tick();
    check_pc_cnt("mis_next", 32'h104, 32'd13);
    check_eq("mis_trap2", {31'b0, misalign_trap}, 32'd0);
`endif

    // Async reset mid-run, during a stall, without a clock edge
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_pc_cnt("arst_run", 32'h0, 32'd0);
    check_eq("arst_run_state", {30'b0, fsm_state}, {30'b0, ST_BOOT});
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();
    check_pc_cnt("rb_run", 32'h0, 32'd0);
    tick();
    tick();
    check_pc_cnt("rb_pc8", 32'h8, 32'd2);

    // Halt at PC 0x8 with count 2
    halt_req = 1'b1;
    jump = 1'b1; jump_index = 26'h40;
    tick();
    clear_inputs();
    check_eq("halt_halted", {31'b0, halted}, 32'd1);
    check_eq("halt_valid", {31'b0, fetch_valid}, 32'd0);
    check_eq("halt_state", {30'b0, fsm_state}, {30'b0, ST_HALT});
    check_pc_cnt("halt", 32'h8, 32'd3);
    // Redirects ignored while halted
    jump_reg = 1'b1; jr_target = 32'h400;
    tick();
    branch_taken = 1'b1; branch_imm = 16'h0004;
    tick();
    clear_inputs();
    check_pc_cnt("halt_hold", 32'h8, 32'd3);
    check_eq("halt_stay", {31'b0, halted}, 32'd1);

    // Async reset while halted
    #2;
    reset = 1'b1;
    #1;
    check_pc_cnt("arst_halt", 32'h0, 32'd0);
    check_eq("arst_halted", {31'b0, halted}, 32'd0);
    check_eq("arst_valid", {31'b0, fetch_valid}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_valid", {31'b0, fetch_valid}, 32'd1);
    tick();
    check_pc_cnt("post_run", 32'h4, 32'd1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
